// File: rtl/tt_sweep_checker_if.sv
// tt_sweep_checker_if
//   Bundles the sweep checker's control/status signals and the stimulus/response
//   pair that connects it to the combinational DUT under self-test.
//   Signals:
//     start            1-cycle sweep request (host -> checker)
//     dut_in           registered stimulus vector (checker -> DUT)
//     dut_out          DUT response (DUT -> checker)
//     busy             sweep in progress
//     done             sweep finished, results valid
//     pass             done with zero mismatches
//     err_count        saturating mismatch count
//     first_fail_valid at least one mismatch recorded
//     first_fail_idx   vector index of the first mismatch
//   Modports: master = checker side, slave = host/DUT side.
interface tt_sweep_checker_if #(
  parameter int unsigned N_IN  = 2,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [N_IN-1:0]  dut_in;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_count;
  logic             first_fail_valid;
  logic [N_IN-1:0]  first_fail_idx;

  modport master (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output err_count,
    output first_fail_valid,
    output first_fail_idx
  );

  modport slave (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  first_fail_valid,
    input  first_fail_idx
  );
endinterface

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
//   On-chip exhaustive self-test for a combinational block. A start pulse sweeps
//   dut_in through every value 0..2**N_IN-1, holds each vector SETTLE+1 cycles,
//   samples dut_out on the last cycle and compares it with EXPECT[vector].
//   Reports pass/fail, a saturating mismatch count and the first failing vector.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, all outputs cleared
//     bus    tt_sweep_checker_if.master (start, dut_in/dut_out, status/results)
module tt_sweep_checker #(
  parameter int unsigned               N_IN   = 2,
  parameter int unsigned               SETTLE = 2,
  parameter logic [(1 << N_IN)-1:0]    EXPECT = 4'b1000,
  parameter int unsigned               CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tt_sweep_checker_if.master   bus
);

  localparam int unsigned       SCNT_W   = 8;
  localparam logic [N_IN-1:0]   VEC_LAST = '1;
  localparam logic [SCNT_W-1:0] SETTLE_C = SCNT_W'(SETTLE);
  localparam logic [CNT_W-1:0]  ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [N_IN-1:0]    vec_q,   vec_d;
  logic [SCNT_W-1:0]  cnt_q,   cnt_d;
  logic [CNT_W-1:0]   err_q,   err_d;
  logic               ffv_q,   ffv_d;
  logic [N_IN-1:0]    ffi_q,   ffi_d;
  logic               busy_q,  busy_d;
  logic               done_q,  done_d;
  logic               pass_q,  pass_d;
  logic               mismatch_c;

  // State and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffi_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffi_q   <= ffi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign mismatch_c = (bus.dut_out != EXPECT[vec_q]);

  // Next-state and result update
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffv_d   = ffv_q;
    ffi_d   = ffi_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        // A start here always begins a fresh sweep and clears prior results
        if (bus.start) begin
          state_d = S_RUN;
          vec_d   = '0;
          cnt_d   = '0;
          err_d   = '0;
          ffv_d   = 1'b0;
          ffi_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end

      S_RUN: begin
        // start is deliberately not looked at while a sweep is running
        if (cnt_q != SETTLE_C) begin
          cnt_d = cnt_q + SCNT_W'(1);
        end else begin
          if (mismatch_c) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + CNT_W'(1);
            end
            if (!ffv_q) begin
              ffv_d = 1'b1;
              ffi_d = vec_q;
            end
          end
          cnt_d = '0;
          if (vec_q == VEC_LAST) begin
            state_d = S_DONE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            // Uses this cycle's updated count so a last-vector miss is included
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // vec_q is forced to 0 outside RUN, so it doubles as the dut_in register
  assign bus.dut_in           = vec_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// tb_tt_sweep_checker
//   Directed bench for tt_sweep_checker. Three instances:
//     A: default parameters, DUT model switchable between AND and OR
//     B: CNT_W=1, DUT output tied high
//     C: SETTLE=0, AND DUT
module tb_tt_sweep_checker;

  logic clk;
  logic rst_a_n, rst_b_n, rst_c_n;
  logic mode_or;
  int   tests;
  int   fails;
  int   n;
  int   bad;

  tt_sweep_checker_if #(.N_IN(2), .CNT_W(8)) bus_a ();
  tt_sweep_checker_if #(.N_IN(2), .CNT_W(1)) bus_b ();
  tt_sweep_checker_if #(.N_IN(2), .CNT_W(8)) bus_c ();

  assign bus_a.dut_out = mode_or ? (|bus_a.dut_in) : (&bus_a.dut_in);
  assign bus_b.dut_out = 1'b1;
  assign bus_c.dut_out = &bus_c.dut_in;

  tt_sweep_checker #(.N_IN(2), .SETTLE(2), .EXPECT(4'b1000), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_a_n), .bus(bus_a)
  );
  tt_sweep_checker #(.N_IN(2), .SETTLE(2), .EXPECT(4'b1000), .CNT_W(1)) u_b (
    .clk(clk), .rst_n(rst_b_n), .bus(bus_b)
  );
  tt_sweep_checker #(.N_IN(2), .SETTLE(0), .EXPECT(4'b1000), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_c_n), .bus(bus_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_a();
    bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
  endtask

  // Counts busy cycles (bounded) and flags samples whose dut_in is not n/3
  task automatic wait_a(output int cyc, output int seq_bad);
    cyc = 0;
    seq_bad = 0;
    while (bus_a.busy === 1'b1 && cyc < 200) begin
      if (bus_a.dut_in !== 2'(cyc / 3)) seq_bad++;
      cyc++;
      tick();
    end
  endtask

  task automatic wait_b(output int cyc);
    cyc = 0;
    while (bus_b.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
  endtask

  // Re-pulses start during cycles 2 of the run; it must be ignored
  task automatic wait_c(output int cyc);
    cyc = 0;
    while (bus_c.busy === 1'b1 && cyc < 200) begin
      bus_c.start = (cyc == 2);
      cyc++;
      tick();
    end
    bus_c.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tests = 0;
    fails = 0;
    clk = 1'b0;
    mode_or = 1'b0;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    rst_c_n = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    bus_c.start = 1'b0;

    // Reset state
    #1;
    check("rst_busy", 32'(bus_a.busy), 0);
    check("rst_done", 32'(bus_a.done), 0);
    check("rst_pass", 32'(bus_a.pass), 0);
    check("rst_err",  32'(bus_a.err_count), 0);
    check("rst_ffv",  32'(bus_a.first_fail_valid), 0);
    check("rst_ffi",  32'(bus_a.first_fail_idx), 0);
    check("rst_dut_in", 32'(bus_a.dut_in), 0);
    #11;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    rst_c_n = 1'b1;
    tick();

    // 1: AND DUT matches expectation
    mode_or = 1'b0;
    pulse_a();
    check("t1_busy_first", 32'(bus_a.busy), 1);
    wait_a(n, bad);
    check("t1_busy_cycles", 32'(n), 12);
    check("t1_dut_in_seq", 32'(bad), 0);
    check("t1_done", 32'(bus_a.done), 1);
    check("t1_pass", 32'(bus_a.pass), 1);
    check("t1_err",  32'(bus_a.err_count), 0);
    check("t1_ffv",  32'(bus_a.first_fail_valid), 0);
    check("t1_dut_in_idle", 32'(bus_a.dut_in), 0);

    // 2: OR DUT mismatches at vectors 1 and 2
    mode_or = 1'b1;
    pulse_a();
    wait_a(n, bad);
    check("t2_busy_cycles", 32'(n), 12);
    check("t2_err",  32'(bus_a.err_count), 2);
    check("t2_ffv",  32'(bus_a.first_fail_valid), 1);
    check("t2_ffi",  32'(bus_a.first_fail_idx), 1);
    check("t2_pass", 32'(bus_a.pass), 0);
    check("t2_done", 32'(bus_a.done), 1);
    repeat (5) tick();
    check("t2_err_stable",  32'(bus_a.err_count), 2);
    check("t2_ffi_stable",  32'(bus_a.first_fail_idx), 1);
    check("t2_done_stable", 32'(bus_a.done), 1);

    // 6: restart from DONE after a failing sweep
    mode_or = 1'b0;
    pulse_a();
    check("t6_done_drop", 32'(bus_a.done), 0);
    check("t6_busy",      32'(bus_a.busy), 1);
    check("t6_err_clr",   32'(bus_a.err_count), 0);
    check("t6_ffv_clr",   32'(bus_a.first_fail_valid), 0);
    wait_a(n, bad);
    check("t6_busy_cycles", 32'(n), 12);
    check("t6_pass", 32'(bus_a.pass), 1);
    check("t6_err",  32'(bus_a.err_count), 0);

    // 5: async reset mid-sweep with a partial error already recorded
    mode_or = 1'b1;
    pulse_a();
    repeat (7) tick();
    check("t5_partial_err", 32'(bus_a.err_count), 1);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("t5_rst_busy",   32'(bus_a.busy), 0);
    check("t5_rst_dut_in", 32'(bus_a.dut_in), 0);
    check("t5_rst_err",    32'(bus_a.err_count), 0);
    check("t5_rst_ffv",    32'(bus_a.first_fail_valid), 0);
    check("t5_rst_done",   32'(bus_a.done), 0);
    @(negedge clk);
    rst_a_n = 1'b1;
    tick();
    mode_or = 1'b0;
    pulse_a();
    wait_a(n, bad);
    check("t5_busy_cycles", 32'(n), 12);
    check("t5_pass", 32'(bus_a.pass), 1);

    // 3: output stuck high, 1-bit saturating counter
    bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    wait_b(n);
    check("t3_busy_cycles", 32'(n), 12);
    check("t3_err_sat", 32'(bus_b.err_count), 1);
    check("t3_ffv",  32'(bus_b.first_fail_valid), 1);
    check("t3_ffi",  32'(bus_b.first_fail_idx), 0);
    check("t3_pass", 32'(bus_b.pass), 0);

    // 4: SETTLE=0, start re-pulsed mid-run
    bus_c.start = 1'b1;
    tick();
    bus_c.start = 1'b0;
    wait_c(n);
    check("t4_busy_cycles", 32'(n), 4);
    check("t4_pass", 32'(bus_c.pass), 1);
    check("t4_done", 32'(bus_c.done), 1);
    repeat (3) tick();
    check("t4_no_restart", 32'(bus_c.busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
